run_length_detector: RTL
========================

Name: run_length_detector

Overview:
Parametrised serial run detector, the next generation of our single-bit zero detector. It watches a serial bit stream sampled on qualified clock edges. It flags when RUN_LEN consecutive samples equal a programmable target bit. Output timing is Mealy or Moore, and runs may be counted overlapping or non-overlapping. The block also exposes the live run length and a saturating detection counter, so it can sit directly behind a serial input stage in lab designs.

Parameters:
RUN_LEN, 3, consecutive target samples needed for a detection; legal range 1..(2**CNT_W)-1
CNT_W, 4, width of run_cnt
HIT_W, 16, width of hit_cnt
TARGET, 0, bit value being counted (0 = zero detector, 1 = ones detector)
MEALY, 1, 1 = combinational y in the sample cycle; 0 = registered y one cycle later
OVERLAP, 1, 1 = every target sample past the threshold also detects; 0 = run_cnt restarts after each detection

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
en  input  1  sample qualifier; x is consumed only on edges where en=1
x  input  1  serial data bit
clr_hits  input  1  synchronous clear of hit_cnt
y  output  1  detection flag
run_cnt  output  CNT_W  current consecutive-target count (registered)
hit_cnt  output  HIT_W  total detections since reset/clear, saturating (registered)

Behaviour:
- Reset (rst=1 at a rising edge):
  - run_cnt <= 0, hit_cnt <= 0, Moore output register <= 0.
  - In Mealy mode y is forced to 0 while rst=1.
  - rst overrides en, x and clr_hits.
- det (internal, combinational) = en & (x==TARGET) & (run_cnt >= RUN_LEN-1) & ~rst.
- run_cnt update on each edge with rst=0:
  - en=0: hold.
  - en=1, x!=TARGET: 0.
  - en=1, x==TARGET, OVERLAP=1: min(run_cnt+1, RUN_LEN), saturates at RUN_LEN.
  - en=1, x==TARGET, OVERLAP=0: 0 if det, else run_cnt+1.
- y:
  - MEALY=1: y = det, zero latency, same cycle as the completing sample.
  - MEALY=0: y_q <= det each edge, one-cycle latency, one-cycle pulse per detection. y_q clears on any edge where det=0, including en=0 cycles.
- hit_cnt, on edges with rst=0:
  - clr_hits=1 and det=1: 1 (clear applied first, then increment).
  - clr_hits=1 and det=0: 0.
  - det=1: hit_cnt+1, holds at 2**HIT_W-1 (no wrap).
  - otherwise: hold.
- en gaps do not break a run: only a non-target qualified sample or rst resets run_cnt.
- RUN_LEN=1: every qualified target sample detects. In non-overlap mode run_cnt stays 0.
- Reset mid-run discards the partial run. A full RUN_LEN new target samples are needed after rst deasserts.
- Equivalent FSM view (OVERLAP=1): states S0..S(RUN_LEN) = run_cnt. A target sample advances one state, saturating at S(RUN_LEN). A non-target sample returns to S0. Detection occurs on the target transition out of S(RUN_LEN-1) or S(RUN_LEN).
- run_cnt width: the parameter check in simulation ($error at time 0) rejects RUN_LEN >= 2**CNT_W or RUN_LEN = 0.

Test Plan:
1. RUN_LEN=3, TARGET=0, MEALY=1, OVERLAP=1, en=1; x = 1,0,0,0,0,1 on successive edges -> y=1 during the 3rd and 4th zero samples only; run_cnt 0,1,2,3,3,0; hit_cnt ends at 2.
2. Same stream with OVERLAP=0 -> y=1 only on the 3rd zero; run_cnt 0,1,2,0,1,0; hit_cnt=1. With MEALY=0 -> y pulses exactly one cycle after the 3rd zero sample.
3. Reset mid-run: x=0,0, then rst=1 for one edge, then x=0,0,0 -> no y during the first two zeros or the reset; y asserts on the 3rd post-reset zero; hit_cnt=1.
4. en gaps: x=0 (en=1), en=0 for 2 cycles with x toggling, then x=0,0 (en=1) -> run_cnt holds at 1 through the gap; y asserts on the second post-gap zero.
5. TARGET=1, RUN_LEN=2, HIT_W=2, OVERLAP=1, x held 1 for 8 edges -> y high from the 2nd edge onward; hit_cnt 0,1,2,3,3,3 (saturates, no wrap).
6. clr_hits: hit_cnt=2; assert clr_hits on a detecting edge -> hit_cnt=1. Assert clr_hits on a non-detecting edge -> hit_cnt=0. run_cnt is unaffected in both cases.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN consecutive TARGET samples.
// Mealy/Moore output, overlap option, live run and hit counters.
module run_length_detector #(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned HIT_W   = 16,
    parameter bit          TARGET  = 1'b0,
    parameter bit          MEALY   = 1'b1,
    parameter bit          OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr_hits,
    output logic             y,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] LEN    = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(RUN_LEN - 1);
    localparam logic [HIT_W-1:0] HIT_MX = '1;

    if (RUN_LEN < 1 || RUN_LEN >= (2 ** CNT_W)) begin : g_bad_len
        $error("run_length_detector: RUN_LEN out of range");
    end

    logic             is_tgt;
    logic             det;
    logic [CNT_W-1:0] run_nxt;
    logic [HIT_W-1:0] hit_nxt;

    always_comb begin
        is_tgt = (x == TARGET);
        det    = en & is_tgt & (run_cnt >= LEN_M1) & ~rst;
    end

    // Overlap saturates at RUN_LEN; non-overlap restarts on each hit.
    always_comb begin
        run_nxt = run_cnt;
        if (en) begin
            if (!is_tgt) begin
                run_nxt = '0;
            end else if (OVERLAP) begin
                run_nxt = (run_cnt >= LEN) ? LEN
                                           : run_cnt + CNT_W'(1);
            end else begin
                run_nxt = det ? '0 : run_cnt + CNT_W'(1);
            end
        end
    end

    // Clear takes effect before the increment of the same edge.
    always_comb begin
        hit_nxt = hit_cnt;
        if (clr_hits) begin
            hit_nxt = det ? HIT_W'(1) : '0;
        end else if (det && hit_cnt != HIT_MX) begin
            hit_nxt = hit_cnt + HIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
            hit_cnt <= '0;
        end else begin
            run_cnt <= run_nxt;
            hit_cnt <= hit_nxt;
        end
    end

    if (MEALY) begin : g_mealy
        assign y = det;
    end else begin : g_moore
        logic y_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                y_q <= 1'b0;
            end else begin
                y_q <= det;
            end
        end
        assign y = y_q;
    end

endmodule
